// File: rtl/rvsoc_dma_pkg.sv
// rvsoc_dma_pkg
//   Shared definitions for the word-copy DMA engine: register offsets
//   (decoded from cfg_addr[3:2]), CTRL bit positions, copy FSM encoding and
//   a byte-strobe expansion helper.
package rvsoc_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_ERR    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } dma_state_e;

  // Expand 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rvsoc_dma_if.sv
// rvsoc_dma_if
//   SoC native memory bus: valid/ready handshake, word address, write data,
//   byte strobes (0 = read) and read data returned with ready.
//   master modport: the initiator (drives valid/addr/wdata/wstrb).
//   slave  modport: the responder (drives ready/rdata).
interface rvsoc_dma_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/rvsoc_dma_regs.sv
// rvsoc_dma_regs
//   CPU-facing responder and register file of the DMA engine.
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset
//     cfg          bus responder (slave modport); ready pulses one cycle
//                  after an access is seen, writes land on that same edge
//     busy         copy in progress (from the FSM); blocks SRC/DST/LEN/START
//     done_set     set DONE
//     err_set      set ERR (stored only with RVSOC_DMA_TIMEOUT_EN)
//     src/dst/len  programmed transfer parameters
//     start        one-cycle pulse when an accepted START is written
//     irq_en, done CTRL bits feeding the interrupt
//   Macro: RVSOC_DMA_TIMEOUT_EN adds the ERR flag storage.
module rvsoc_dma_regs
  import rvsoc_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  rvsoc_dma_if.slave       cfg,
  input  logic             busy,
  input  logic             done_set,
  input  logic             err_set,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             start,
  output logic             irq_en,
  output logic             done
);

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             err_rd;
  logic             accept, wr_en, rd_en, ctrl_wr;
  logic [1:0]       sel;
  logic [31:0]      byte_mask;
  logic [31:0]      ctrl_rd;

`ifdef RVSOC_DMA_TIMEOUT_EN
  logic err_q, err_d;
  assign err_rd = err_q;
`else
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign err_rd = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{cfg.addr[31:4], cfg.addr[1:0]};

  always_comb begin
    // Accept only while ready is low so each request yields exactly one pulse.
    accept    = cfg.valid && !ready_q;
    wr_en     = accept && (cfg.wstrb != 4'h0);
    rd_en     = accept && (cfg.wstrb == 4'h0);
    sel       = cfg.addr[3:2];
    byte_mask = strb_mask(cfg.wstrb);
    ctrl_wr   = wr_en && (sel == REG_CTRL) && cfg.wstrb[0];
    start     = ctrl_wr && cfg.wdata[CTRL_START] && !busy;
    ready_d   = accept;

    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
`ifdef RVSOC_DMA_TIMEOUT_EN
    err_d    = err_q;
`endif

    if (wr_en && !busy) begin
      case (sel)
        REG_SRC: src_d = ((src_q & ~byte_mask) | (cfg.wdata & byte_mask)) & 32'hFFFF_FFFC;
        REG_DST: dst_d = ((dst_q & ~byte_mask) | (cfg.wdata & byte_mask)) & 32'hFFFF_FFFC;
        REG_LEN: len_d = (len_q & ~byte_mask[LEN_W-1:0]) |
                         (cfg.wdata[LEN_W-1:0] & byte_mask[LEN_W-1:0]);
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      irq_en_d = cfg.wdata[CTRL_IRQ_EN];
      if (cfg.wdata[CTRL_DONE]) done_d = 1'b0;
`ifdef RVSOC_DMA_TIMEOUT_EN
      if (cfg.wdata[CTRL_ERR]) err_d = 1'b0;
`endif
    end

    // Hardware set beats a simultaneous W1C.
    if (done_set) done_d = 1'b1;
`ifdef RVSOC_DMA_TIMEOUT_EN
    if (err_set) err_d = 1'b1;
`endif

    // A new transfer starts with clean status, even if DONE was written too.
    if (start) begin
      done_d = 1'b0;
`ifdef RVSOC_DMA_TIMEOUT_EN
      err_d  = 1'b0;
`endif
    end

    ctrl_rd              = '0;
    ctrl_rd[CTRL_BUSY]   = busy;
    ctrl_rd[CTRL_DONE]   = done_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
    ctrl_rd[CTRL_ERR]    = err_rd;

    rdata_d = '0;
    if (rd_en) begin
      case (sel)
        REG_SRC:  rdata_d = src_q;
        REG_DST:  rdata_d = dst_q;
        REG_LEN:  rdata_d = 32'(len_q);
        default:  rdata_d = ctrl_rd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef RVSOC_DMA_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
`ifdef RVSOC_DMA_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign cfg.ready = ready_q;
  assign cfg.rdata = rdata_q;
  assign src       = src_q;
  assign dst       = dst_q;
  assign len       = len_q;
  assign irq_en    = irq_en_q;
  assign done      = done_q;

endmodule

// File: rtl/rvsoc_dma_master.sv
// rvsoc_dma_master
//   Word-copy DMA engine. Copies LEN 32-bit words from SRC to DST using one
//   bus read and one bus write per word, then raises DONE.
//   Ports:
//     clk, resetn  clock, asynchronous active-low reset
//     cfg          register port (slave modport), see rvsoc_dma_regs
//     m            memory bus initiator (master modport); every request is
//                  preceded by at least one idle cycle
//     irq_done     level interrupt, DONE & IRQ_EN
//   Parameters: LEN_W (LEN register width), TIMEOUT_CYCLES (stall limit).
//   Macro: RVSOC_DMA_TIMEOUT_EN aborts a request stalled TIMEOUT_CYCLES
//   cycles, setting ERR and DONE; without it the engine waits forever.
module rvsoc_dma_master
  import rvsoc_dma_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  rvsoc_dma_if.slave  cfg,
  rvsoc_dma_if.master m,
  output logic        irq_done
);

  dma_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [31:0]      cur_src_q, cur_src_d;
  logic [31:0]      cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic             busy, done_set, err_set, start, irq_en, done;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;

`ifdef RVSOC_DMA_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  rvsoc_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk      (clk),
    .resetn   (resetn),
    .cfg      (cfg),
    .busy     (busy),
    .done_set (done_set),
    .err_set  (err_set),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .start    (start),
    .irq_en   (irq_en),
    .done     (done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
      data_q    <= '0;
`ifdef RVSOC_DMA_TIMEOUT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
`ifdef RVSOC_DMA_TIMEOUT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  // Each RD/WR phase spends one cycle with valid low, then raises valid and
  // holds it until ready; this gives the mandatory idle gap between requests.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    done_set  = 1'b0;
    err_set   = 1'b0;
`ifdef RVSOC_DMA_TIMEOUT_EN
    stall_d   = stall_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_src_d = src;
          cur_dst_d = dst;
          rem_d     = len;
          state_d   = (len == '0) ? ST_FIN : ST_RD;
        end
      end
      ST_RD: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (m.ready) begin
          valid_d = 1'b0;
          data_d  = m.rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (m.ready) begin
          valid_d   = 1'b0;
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          rem_d     = rem_q - LEN_W'(1);
          state_d   = (rem_q == LEN_W'(1)) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef RVSOC_DMA_TIMEOUT_EN
    // Counter restarts with every new request and runs only while stalled.
    if (!valid_q) begin
      stall_d = '0;
    end else if (!m.ready) begin
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
        valid_d  = 1'b0;
        done_set = 1'b1;
        err_set  = 1'b1;
        state_d  = ST_IDLE;
        stall_d  = '0;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
`endif
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    m.valid  = valid_q;
    m.addr   = '0;
    m.wdata  = '0;
    m.wstrb  = 4'h0;
    case (state_q)
      ST_RD: m.addr = cur_src_q;
      ST_WR: begin
        m.addr  = cur_dst_q;
        m.wdata = data_q;
        m.wstrb = 4'hF;
      end
      default: ;
    endcase
    irq_done = done & irq_en;
  end

endmodule

// File: tb/tb_rvsoc_dma_master.sv
module tb_rvsoc_dma_master;

  localparam logic [3:0] O_SRC  = 4'h0;
  localparam logic [3:0] O_DST  = 4'h4;
  localparam logic [3:0] O_LEN  = 4'h8;
  localparam logic [3:0] O_CTRL = 4'hC;

  logic clk = 1'b0;
  logic resetn;
  logic irq_done;
  always #5 clk = ~clk;

  rvsoc_dma_if cfg_if ();
  rvsoc_dma_if m_if ();

  rvsoc_dma_master #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cfg      (cfg_if),
    .m        (m_if),
    .irq_done (irq_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory responder model ----------------
  int   ws = 0;
  int   wcnt = 0;
  logic tie_low = 1'b0;
  logic idle_ready = 1'b0;
  logic [31:0] wmem [0:1023];
  logic        wflag [0:1023];

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_C3C3;
  endfunction

  assign m_if.ready = m_if.valid ? (!tie_low && (wcnt >= ws)) : idle_ready;
  assign m_if.rdata = pattern(m_if.addr);

  always @(posedge clk) begin
    if (!m_if.valid || m_if.ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (m_if.valid && m_if.ready && m_if.wstrb == 4'hF) begin
      wmem[m_if.addr[11:2]]  <= m_if.wdata;
      wflag[m_if.addr[11:2]] <= 1'b1;
    end
  end

  // ---------------- bus monitor ----------------
  int vcnt = 0, rd_cnt = 0, wr_cnt = 0, stab_err = 0, gap_err = 0, burst_err = 0, run = 0;
  logic pv = 1'b0, pr = 1'b0, ph = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0]  ps = '0;

  always @(negedge clk) begin
    if (m_if.valid) begin
      vcnt <= vcnt + 1;
      if (pv && !pr && (m_if.addr != pa || m_if.wdata != pd || m_if.wstrb != ps))
        stab_err <= stab_err + 1;
      if (ph) gap_err <= gap_err + 1;
      if (m_if.ready) begin
        if (run != ws) burst_err <= burst_err + 1;
        run <= 0;
        if (m_if.wstrb == 4'hF) wr_cnt <= wr_cnt + 1;
        else rd_cnt <= rd_cnt + 1;
      end else begin
        run <= run + 1;
      end
    end else begin
      run <= 0;
    end
    pv <= m_if.valid;
    pr <= m_if.ready;
    ph <= m_if.valid && m_if.ready;
    pa <= m_if.addr;
    pd <= m_if.wdata;
    ps <= m_if.wstrb;
  end

  // ---------------- cfg access tasks (called at negedge) ----------------
  task automatic cfg_access(input logic [3:0] off, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd = '0;
    cfg_if.addr  = {28'h0, off};
    cfg_if.wdata = wd;
    cfg_if.wstrb = strb;
    cfg_if.valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cfg_if.ready) begin
        got = 1'b1;
        rd  = cfg_if.rdata;
        break;
      end
    end
    cfg_if.valid = 1'b0;
    cfg_if.wstrb = 4'h0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_ready_timeout: got no ready, expected ready within 20 cycles (off 0x%0h)", off);
    end
  endtask

  task automatic cfg_wr(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] dummy;
    cfg_access(off, wd, strb, dummy);
  endtask

  task automatic cfg_rd(input logic [3:0] off, output logic [31:0] rd);
    cfg_access(off, 32'h0, 4'h0, rd);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (irq_done) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got irq_done=0, expected 1 within %0d cycles", limit);
    end
  endtask

  task automatic check_copy(input string name, input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    for (int i = 0; i < n; i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      check($sformatf("%s_word%0d", name, i), wmem[da[11:2]], pattern(sa));
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  off;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin : main
    logic [31:0] r;
    logic [31:0] a;
    int cyc, v0, r0, w0;

    vecs[0]  = '{1'b0, O_SRC,  32'h0,         4'h0, 32'h0};
    vecs[1]  = '{1'b0, O_DST,  32'h0,         4'h0, 32'h0};
    vecs[2]  = '{1'b0, O_LEN,  32'h0,         4'h0, 32'h0};
    vecs[3]  = '{1'b0, O_CTRL, 32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, O_SRC,  32'h1234_5677, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, O_SRC,  32'h0,         4'h0, 32'h1234_5674};
    vecs[6]  = '{1'b1, O_SRC,  32'hAABB_CCDD, 4'h2, 32'h0};
    vecs[7]  = '{1'b0, O_SRC,  32'h0,         4'h0, 32'h1234_CC74};
    vecs[8]  = '{1'b1, O_DST,  32'hFFFF_FFFF, 4'h8, 32'h0};
    vecs[9]  = '{1'b0, O_DST,  32'h0,         4'h0, 32'hFF00_0000};
    vecs[10] = '{1'b1, O_LEN,  32'hABCD_1234, 4'hF, 32'h0};
    vecs[11] = '{1'b0, O_LEN,  32'h0,         4'h0, 32'h0000_1234};
    vecs[12] = '{1'b1, O_LEN,  32'h0000_FF00, 4'h1, 32'h0};
    vecs[13] = '{1'b0, O_LEN,  32'h0,         4'h0, 32'h0000_1200};
    vecs[14] = '{1'b1, O_CTRL, 32'h0000_0008, 4'h1, 32'h0};
    vecs[15] = '{1'b0, O_CTRL, 32'h0,         4'h0, 32'h0000_0008};
    vecs[16] = '{1'b1, O_CTRL, 32'h0000_0000, 4'hE, 32'h0};
    vecs[17] = '{1'b0, O_CTRL, 32'h0,         4'h0, 32'h0000_0008};
    vecs[18] = '{1'b1, O_CTRL, 32'h0000_001C, 4'h1, 32'h0};
    vecs[19] = '{1'b0, O_CTRL, 32'h0,         4'h0, 32'h0000_0008};
    vecs[20] = '{1'b1, O_CTRL, 32'h0000_0000, 4'h1, 32'h0};
    vecs[21] = '{1'b0, O_CTRL, 32'h0,         4'h0, 32'h0000_0000};

    cfg_if.valid = 1'b0;
    cfg_if.addr  = '0;
    cfg_if.wdata = '0;
    cfg_if.wstrb = 4'h0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", {31'b0, m_if.valid}, 32'h0);
    check("rst_m_wstrb", {28'b0, m_if.wstrb}, 32'h0);
    check("rst_cfg_ready", {31'b0, cfg_if.ready}, 32'h0);
    check("rst_irq_done", {31'b0, irq_done}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].wr) begin
        cfg_wr(vecs[i].off, vecs[i].data, vecs[i].strb);
      end else begin
        cfg_rd(vecs[i].off, r);
        check($sformatf("vec%0d", i), r, vecs[i].exp);
      end
    end

    // Four-word zero-wait copy.
    cfg_wr(O_SRC, 32'h100, 4'hF);
    cfg_wr(O_DST, 32'h200, 4'hF);
    cfg_wr(O_LEN, 32'd4, 4'hF);
    r0 = rd_cnt; w0 = wr_cnt;
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    wait_done(200, cyc);
    check("t1_cycles_16_to_20", {31'b0, (cyc >= 16 && cyc <= 20)}, 32'h1);
    check_copy("t1", 32'h100, 32'h200, 4);
    check("t1_reads", 32'(rd_cnt - r0), 32'd4);
    check("t1_writes", 32'(wr_cnt - w0), 32'd4);
    check("t1_gap_err", 32'(gap_err), 32'd0);
    check("t1_burst_err", 32'(burst_err), 32'd0);
    cfg_rd(O_CTRL, r);
    check("t1_ctrl", r, 32'h0000_000C);

    // LEN=0: DONE one cycle after START, no bus traffic.
    v0 = vcnt;
    cfg_wr(O_LEN, 32'd0, 4'hF);
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    check("t2_done_cleared", {31'b0, irq_done}, 32'h0);
    @(negedge clk);
    check("t2_done_set", {31'b0, irq_done}, 32'h1);
    repeat (3) @(negedge clk);
    check("t2_no_valid", 32'(vcnt - v0), 32'd0);

    // Three wait states, ready high while idle must be ignored.
    ws = 3; idle_ready = 1'b1;
    cfg_wr(O_SRC, 32'h300, 4'hF);
    cfg_wr(O_DST, 32'h400, 4'hF);
    cfg_wr(O_LEN, 32'd2, 4'hF);
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    wait_done(300, cyc);
    check("t3_cycles_ge20", {31'b0, (cyc >= 20)}, 32'h1);
    check_copy("t3", 32'h300, 32'h400, 2);
    check("t3_stable_err", 32'(stab_err), 32'd0);
    check("t3_burst_err", 32'(burst_err), 32'd0);
    ws = 0; idle_ready = 1'b0;

    // Source address wraps from 0xFFFF_FFFC to 0.
    cfg_wr(O_SRC, 32'hFFFF_FFFF, 4'hF);
    cfg_wr(O_DST, 32'h800, 4'hF);
    cfg_wr(O_LEN, 32'd2, 4'hF);
    cfg_rd(O_SRC, r);
    check("wrap_src_aligned", r, 32'hFFFF_FFFC);
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    wait_done(200, cyc);
    check("wrap_word0", wmem[512], pattern(32'hFFFF_FFFC));
    check("wrap_word1", wmem[513], pattern(32'h0000_0000));

    // START together with DONE, then writes while BUSY.
    cfg_wr(O_SRC, 32'h100, 4'hF);
    cfg_wr(O_DST, 32'h600, 4'hF);
    cfg_wr(O_LEN, 32'd3, 4'hF);
    cfg_wr(O_CTRL, 32'hD, 4'h1);
    cfg_rd(O_CTRL, r);
    check("t4_ctrl_busy", r, 32'h0000_000A);
    cfg_wr(O_SRC, 32'hDEAD, 4'hF);
    cfg_wr(O_LEN, 32'd7, 4'hF);
    cfg_rd(O_SRC, r);
    check("t4_src_kept", r, 32'h0000_0100);
    cfg_rd(O_LEN, r);
    check("t4_len_kept", r, 32'd3);
    wait_done(200, cyc);
    check_copy("t4", 32'h100, 32'h600, 3);

`ifdef RVSOC_DMA_TIMEOUT_EN
    tie_low = 1'b1;
    cfg_wr(O_SRC, 32'h100, 4'hF);
    cfg_wr(O_DST, 32'h900, 4'hF);
    cfg_wr(O_LEN, 32'd1, 4'hF);
    v0 = vcnt;
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    wait_done(100, cyc);
    check("t6_stall_cycles", 32'(vcnt - v0), 32'd8);
    check("t6_valid_dropped", {31'b0, m_if.valid}, 32'h0);
    cfg_rd(O_CTRL, r);
    check("t6_ctrl_err", r, 32'h0000_001C);
    check("t6_no_write", {31'b0, (wflag[576] === 1'b1)}, 32'h0);
    tie_low = 1'b0;
    cfg_wr(O_CTRL, 32'h18, 4'h1);
    cfg_rd(O_CTRL, r);
    check("t6_err_cleared", r, 32'h0000_000C);
`else
    cfg_wr(O_CTRL, 32'h18, 4'h1);
    cfg_rd(O_CTRL, r);
    check("err_reads_zero", r, 32'h0000_000C);
`endif

    // Reset during the write of word 2 (index 1).
    cfg_wr(O_SRC, 32'h100, 4'hF);
    cfg_wr(O_DST, 32'h700, 4'hF);
    cfg_wr(O_LEN, 32'd4, 4'hF);
    w0 = wr_cnt;
    cfg_wr(O_CTRL, 32'h9, 4'h1);
    cyc = -1;
    for (int i = 0; i < 100; i++) begin
      if (m_if.valid && m_if.wstrb == 4'hF && (wr_cnt - w0) == 1) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
    check("t5_found_wr2", {31'b0, (cyc >= 0)}, 32'h1);
    resetn = 1'b0;
    #1;
    check("t5_valid_drop", {31'b0, m_if.valid}, 32'h0);
    check("t5_irq_low", {31'b0, irq_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    a = 32'h704;
    check("t5_no_partial", {31'b0, (wflag[a[11:2]] === 1'b1)}, 32'h0);
    check("t5_word0", wmem[448], pattern(32'h100));
    cfg_rd(O_SRC, r);  check("t5_src_zero", r, 32'h0);
    cfg_rd(O_DST, r);  check("t5_dst_zero", r, 32'h0);
    cfg_rd(O_LEN, r);  check("t5_len_zero", r, 32'h0);
    cfg_rd(O_CTRL, r); check("t5_ctrl_zero", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
